// File: rtl/wb_vmemem_bridge.sv
// Pipelined Wishbone slave to VME-style memory target bridge.
// One access is outstanding at a time. Each request is latched, turned into
// a single-cycle read or write strobe, and answered with a registered one-cycle
// ack or err. A target that stays silent is aborted after TIMEOUT wait cycles.
module wb_vmemem_bridge #(
  parameter int unsigned TIMEOUT = 255  // wait cycles before abort, 1..255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  // Wishbone pipelined slave
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [17:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic [31:0] wb_dat_o,
  // memory target
  output logic [17:0] VMEAddr,
  output logic [31:0] VMEWrData,
  output logic        VMERdMem,
  output logic        VMEWrMem,
  input  logic [31:0] VMERdData,
  input  logic        VMERdDone,
  input  logic        VMEWrDone,
  input  logic        VMERdError,
  input  logic        VMEWrError
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic        we_q;
  logic        aborted_q;

  logic        accept;
  logic        bad_sel;
  logic        done_m;
  logic        err_m;
  logic        timeout_hit;
  logic        abort_now;

  logic        ack_d;
  logic        err_d;
  logic        rd_mem_d;
  logic        wr_mem_d;

  // A new request can only be taken while no access is in flight.
  assign accept  = ((state_q == S_IDLE) || (state_q == S_RESP)) && wb_cyc_i && wb_stb_i;
  // Partial writes are not supported by the target; they are refused up front.
  assign bad_sel = wb_we_i && (wb_sel_i != 4'hF);

  // Only the completion/error lines matching the access direction count.
  assign done_m      = we_q ? VMEWrDone  : VMERdDone;
  assign err_m       = we_q ? VMEWrError : VMERdError;
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_CNT);
  // The master may drop the cycle in the completing cycle itself.
  assign abort_now   = aborted_q || !wb_cyc_i;

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: defaults are assigned first so every path drives every output and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = bad_sel ? S_RESP : S_STROBE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (err_m || done_m || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall follows the state, the rest are next values of
  // registered one-cycle pulses.
  always_comb begin
    wb_stall_o = (state_q == S_STROBE) || (state_q == S_WAIT);
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rd_mem_d   = 1'b0;
    wr_mem_d   = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (bad_sel) begin
            err_d = 1'b1;
          end else begin
            rd_mem_d = !wb_we_i;
            wr_mem_d = wb_we_i;
          end
        end
      end
      S_WAIT: begin
        // Error has priority over Done; a timeout reports as an error.
        if (err_m) begin
          err_d = !abort_now;
        end else if (done_m) begin
          ack_d = !abort_now;
        end else if (timeout_hit) begin
          err_d = !abort_now;
        end
      end
      default: ;
    endcase
  end

  // Registered response and target strobe pulses.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
    end else begin
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      VMERdMem <= rd_mem_d;
      VMEWrMem <= wr_mem_d;
    end
  end

  // Request latch, abort tracking, wait counter and read-data capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      VMEAddr   <= '0;
      VMEWrData <= '0;
      we_q      <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
      wb_dat_o  <= '0;
    end else begin
      // Address and data stay put until the next accepted request.
      if (accept) begin
        VMEAddr   <= wb_adr_i;
        VMEWrData <= wb_dat_i;
        we_q      <= wb_we_i;
        aborted_q <= 1'b0;
      end else if (((state_q == S_STROBE) || (state_q == S_WAIT)) && !wb_cyc_i) begin
        aborted_q <= 1'b1;
      end

      if (state_q == S_STROBE) begin
        cnt_q <= '0;
      end else if ((state_q == S_WAIT) && !(err_m || done_m)) begin
        cnt_q <= cnt_inc;
      end

      if ((state_q == S_WAIT) && !we_q && VMERdDone && !VMERdError) begin
        wb_dat_o <= VMERdData;
      end
    end
  end

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
// Self-checking bench for wb_vmemem_bridge: directed scenarios followed by
// randomized single transactions, each predicted by a per-transaction model.
module tb_wb_vmemem_bridge;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [17:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [31:0] wb_dat_o;
  logic [17:0] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem, VMEWrMem;
  logic [31:0] VMERdData;
  logic        VMERdDone, VMEWrDone, VMERdError, VMEWrError;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdat_model;   // value wb_dat_o must hold
  int last_stall_cnt;

  always #5 Clk = ~Clk;

  wb_vmemem_bridge #(.TIMEOUT(TO)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_stall_o (wb_stall_o),
    .wb_dat_o   (wb_dat_o),
    .VMEAddr    (VMEAddr),
    .VMEWrData  (VMEWrData),
    .VMERdMem   (VMERdMem),
    .VMEWrMem   (VMEWrMem),
    .VMERdData  (VMERdData),
    .VMERdDone  (VMERdDone),
    .VMEWrDone  (VMEWrDone),
    .VMERdError (VMERdError),
    .VMEWrError (VMEWrError)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic target_noise();
    VMERdDone  = 1'($urandom);
    VMEWrDone  = 1'($urandom);
    VMERdError = 1'($urandom);
    VMEWrError = 1'($urandom);
    VMERdData  = $urandom;
  endtask

  // One Wishbone transaction.
  //   lat   : wait-cycle index (1..TO) at which the target answers, 0 = silent
  //   tdone/terr : what the target drives when it answers
  //   drop  : wait-cycle index from which cyc is low (0 = strobe cycle), -1 = never
  task automatic do_txn(input logic we, input logic [17:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int lat, input logic tdone,
                        input logic terr, input logic [31:0] rdata, input int drop);
    logic bad, responds, exp_ack, exp_err;
    int   k_end, c_resp, stall_cnt;
    bad       = we && (sel != 4'hF);
    responds  = (lat >= 1) && (lat <= TO) && (tdone || terr);
    k_end     = responds ? lat : TO;
    stall_cnt = 0;
    if (bad) begin
      c_resp  = 1;
      exp_ack = 1'b0;
      exp_err = 1'b1;
    end else begin
      c_resp  = k_end + 2;
      exp_ack = responds && !terr;
      exp_err = !exp_ack;
      if (drop >= 0 && drop <= k_end) begin
        exp_ack = 1'b0;
        exp_err = 1'b0;
      end
    end

    @(posedge Clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    target_noise();
    @(negedge Clk);
    check("stall_at_accept", 32'(wb_stall_o), 32'(0));

    for (int c = 1; c <= c_resp; c++) begin
      @(posedge Clk); #1;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'($urandom);
      wb_adr_i = 18'($urandom);
      wb_dat_i = $urandom;
      wb_sel_i = 4'($urandom);
      wb_cyc_i = !(drop >= 0 && c >= drop + 1);
      if (!bad && c >= 2 && c < c_resp) begin
        // while waiting only the other direction's lines may toggle
        VMERdData = $urandom;
        if (we) begin
          VMERdDone = 1'($urandom); VMERdError = 1'($urandom);
          VMEWrDone = 1'b0;         VMEWrError = 1'b0;
        end else begin
          VMEWrDone = 1'($urandom); VMEWrError = 1'($urandom);
          VMERdDone = 1'b0;         VMERdError = 1'b0;
        end
      end else begin
        target_noise();
      end
      if (!bad && lat >= 1 && lat <= TO && c == lat + 1) begin
        if (we) begin
          VMEWrDone = tdone; VMEWrError = terr;
        end else begin
          VMERdDone = tdone; VMERdError = terr; VMERdData = rdata;
        end
      end
      if (c == c_resp && !bad && !we && responds && !terr) rdat_model = rdata;
      @(negedge Clk);
      check("stall",  32'(wb_stall_o), 32'(c < c_resp));
      check("rdmem",  32'(VMERdMem),   32'(!bad && !we && c == 1));
      check("wrmem",  32'(VMEWrMem),   32'(!bad && we && c == 1));
      check("ack",    32'(wb_ack_o),   32'(c == c_resp && exp_ack));
      check("err",    32'(wb_err_o),   32'(c == c_resp && exp_err));
      check("addr",   32'(VMEAddr),    32'(adr));
      check("wdata",  VMEWrData,       dat);
      check("rdat",   wb_dat_o,        rdat_model);
      stall_cnt += int'(wb_stall_o);
    end
    last_stall_cnt = stall_cnt;

    // quiet cycle: nothing may follow the response
    @(posedge Clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    target_noise();
    @(negedge Clk);
    check("idle_ack",   32'(wb_ack_o),   32'(0));
    check("idle_err",   32'(wb_err_o),   32'(0));
    check("idle_stall", 32'(wb_stall_o), 32'(0));
    check("idle_rdat",  wb_dat_o,        rdat_model);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(wb_ack_o),   32'(0));
    check({tag, "_err"},   32'(wb_err_o),   32'(0));
    check({tag, "_stall"}, 32'(wb_stall_o), 32'(0));
    check({tag, "_dat"},   wb_dat_o,        32'(0));
    check({tag, "_addr"},  32'(VMEAddr),    32'(0));
    check({tag, "_wdata"}, VMEWrData,       32'(0));
    check({tag, "_rdmem"}, 32'(VMERdMem),   32'(0));
    check({tag, "_wrmem"}, 32'(VMEWrMem),   32'(0));
  endtask

  initial begin
    logic we;
    logic [3:0] sel;
    int lat, drop;

    Rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
    VMERdError = 1'b0; VMEWrError = 1'b0;
    rdat_model = '0;
    #12;
    check_reset_outputs("por");
    @(negedge Clk);
    Rst_n = 1'b1;

    // write, Done after two quiet cycles following the strobe
    do_txn(1'b1, 18'h0, 32'hDEADBEEF, 4'hF, 3, 1'b1, 1'b0, 32'h0, -1);
    check("write_stall_cycles", 32'(last_stall_cnt), 32'(4));
    // read returning data together with Done
    do_txn(1'b0, 18'h1, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'h00010203, -1);
    check("read_data_held", wb_dat_o, 32'h00010203);
    // silent target: timeout error, then a normal request
    do_txn(1'b0, 18'h2, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, -1);
    check("timeout_stall_cycles", 32'(last_stall_cnt), 32'(TO + 1));
    do_txn(1'b1, 18'h3, 32'h12345678, 4'hF, 1, 1'b1, 1'b0, 32'h0, -1);
    // partial write refused
    do_txn(1'b1, 18'h4, 32'h55AA55AA, 4'h3, 0, 1'b0, 1'b0, 32'h0, -1);
    // Done and Error together on a read
    do_txn(1'b0, 18'h5, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'hFFFF0000, -1);
    check("err_keeps_rdat", wb_dat_o, 32'h00010203);
    // Error without Done on a write
    do_txn(1'b1, 18'h7, 32'hCAFEF00D, 4'hF, 4, 1'b0, 1'b1, 32'h0, -1);
    // master abandons the cycle during the wait
    do_txn(1'b0, 18'h6, 32'h0, 4'hF, 3, 1'b1, 1'b0, 32'hA5A5A5A5, 1);
    do_txn(1'b1, 18'h8, 32'h0BADF00D, 4'hF, 2, 1'b1, 1'b0, 32'h0, 0);

    // reset pulsed mid-access
    @(posedge Clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 18'h9; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdError = 1'b0; VMEWrError = 1'b0;
    @(posedge Clk); #1;
    wb_stb_i = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    rdat_model = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk); #1;
      VMERdData = $urandom;
      VMERdDone = (c == 1);
      VMERdError = 1'b0;
      @(negedge Clk);
      check("post_rst_ack",   32'(wb_ack_o),   32'(0));
      check("post_rst_err",   32'(wb_err_o),   32'(0));
      check("post_rst_stall", 32'(wb_stall_o), 32'(0));
      check("post_rst_rdat",  wb_dat_o,        32'(0));
    end
    wb_cyc_i = 1'b0;

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom);
      sel  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      lat  = $urandom_range(0, TO);
      drop = ($urandom_range(0, 5) == 0 && !(we && sel != 4'hF)) ?
             $urandom_range(0, TO) : -1;
      do_txn(we, 18'($urandom), $urandom, sel, lat, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), $urandom, drop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
